// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_pkg
//  Description : Shared constants for the serial 16-bit Hack ALU:
//                datapath geometry, FSM state encodings and the bit
//                positions of the six Hack control bits inside the
//                packed control word {zx,nx,zy,ny,f,no}.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu16_pkg;

    localparam int unsigned ALU_SLICES  = 4;
    localparam int unsigned ALU_SLICE_W = 4;
    localparam int unsigned ALU_W       = ALU_SLICES * ALU_SLICE_W;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the packed control word {zx,nx,zy,ny,f,no}
    localparam int unsigned CTL_W  = 6;
    localparam int unsigned CTL_ZX = 5;
    localparam int unsigned CTL_NX = 4;
    localparam int unsigned CTL_ZY = 3;
    localparam int unsigned CTL_NY = 2;
    localparam int unsigned CTL_F  = 1;
    localparam int unsigned CTL_NO = 0;

endpackage : alu16_pkg
`default_nettype wire

// File: rtl/alu16_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_serial_if
//  Description : Operand/result handshake bundle for alu16_serial.
//                Input side  : in_valid/in_ready, x, y, zx..no
//                Output side : out_valid/out_ready, out, zr, ng, cout
//                slave  modport - used by the ALU
//                master modport - used by the producer/consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu16_serial_if
    import alu16_pkg::*;
();

    logic             in_valid;
    logic             in_ready;
    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;

    logic             out_valid;
    logic             out_ready;
    logic [ALU_W-1:0] out;
    logic             zr;
    logic             ng;
    logic             cout;

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        output in_ready, out_valid, out, zr, ng, cout
    );

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        input  in_ready, out_valid, out, zr, ng, cout
    );

endinterface : alu16_serial_if
`default_nettype wire

// File: rtl/alu16_serial_alu4.sv
`default_nettype none
// ============================================================================
//  Module      : ALU4
//  Description : Combinational 4-bit Hack ALU slice with carry in/out.
//                i_x, i_y   : 4-bit operand nibbles
//                i_zx..i_no : Hack controls
//                i_cin      : carry into the adder (ignored when i_f=0)
//                o_out      : 4-bit slice result
//                o_cout     : adder carry out, 0 when i_f=0
//  Revision    : 1.0 - initial release
// ============================================================================
module ALU4 (
    input  wire logic [3:0] i_x,
    input  wire logic [3:0] i_y,
    input  wire logic       i_zx,
    input  wire logic       i_nx,
    input  wire logic       i_zy,
    input  wire logic       i_ny,
    input  wire logic       i_f,
    input  wire logic       i_no,
    input  wire logic       i_cin,
    output logic      [3:0] o_out,
    output logic            o_cout
);

    logic [3:0] w_xz;
    logic [3:0] w_xn;
    logic [3:0] w_yz;
    logic [3:0] w_yn;
    logic [4:0] w_sum;
    logic [3:0] w_fn;

    assign w_xz  = i_zx ? 4'h0 : i_x;
    assign w_xn  = i_nx ? ~w_xz : w_xz;
    assign w_yz  = i_zy ? 4'h0 : i_y;
    assign w_yn  = i_ny ? ~w_yz : w_yz;

    assign w_sum = {1'b0, w_xn} + {1'b0, w_yn} + {4'h0, i_cin};
    assign w_fn  = i_f ? w_sum[3:0] : (w_xn & w_yn);

    assign o_out  = i_no ? ~w_fn : w_fn;
    // The AND path has no carry, so the chain is cleared for f=0.
    assign o_cout = i_f & w_sum[4];

endmodule : ALU4
`default_nettype wire

// File: rtl/alu16_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_serial
//  Description : Multi-cycle 16-bit Hack ALU. One ALU4 slice is reused for
//                four passes, least-significant nibble first, with the
//                carry chained through a register between passes.
//                clk   : clock, rising edge
//                rst_n : synchronous active-low reset
//                bus   : alu16_serial_if.slave - input handshake with
//                        operands/controls, output handshake with result
//                        and zr/ng/cout flags
//                Latency 4 cycles accept-to-out_valid, all outputs
//                registered or decoded directly from state.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu16_serial
    import alu16_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    alu16_serial_if.slave   bus
);

    localparam logic [1:0] c_K_LAST = 2'(ALU_SLICES - 1);

    logic [1:0]             r_state;
    logic [1:0]             r_k;
    logic [ALU_W-1:0]       r_x;
    logic [ALU_W-1:0]       r_y;
    logic [CTL_W-1:0]       r_ctl;
    logic                   r_carry;
    logic [ALU_W-1:0]       r_result;
    // Set when any produced nibble was non-zero. Resets to 1 so that zr
    // reads 0 out of reset; cleared on every accept.
    logic                   r_nz_acc;

    logic [ALU_SLICE_W-1:0] w_x_nib;
    logic [ALU_SLICE_W-1:0] w_y_nib;
    logic                   w_cin;
    logic [ALU_SLICE_W-1:0] w_slice_out;
    logic                   w_slice_cout;
    logic [3:0]             w_base;

    assign w_base  = {r_k, 2'b00};
    assign w_x_nib = r_x[w_base +: ALU_SLICE_W];
    assign w_y_nib = r_y[w_base +: ALU_SLICE_W];
    assign w_cin   = (r_k == 2'd0) ? 1'b0 : r_carry;

    ALU4 u_alu4 (
        .i_x    (w_x_nib),
        .i_y    (w_y_nib),
        .i_zx   (r_ctl[CTL_ZX]),
        .i_nx   (r_ctl[CTL_NX]),
        .i_zy   (r_ctl[CTL_ZY]),
        .i_ny   (r_ctl[CTL_NY]),
        .i_f    (r_ctl[CTL_F]),
        .i_no   (r_ctl[CTL_NO]),
        .i_cin  (w_cin),
        .o_out  (w_slice_out),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= 2'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_ctl    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_nz_acc <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_x      <= bus.x;
                        r_y      <= bus.y;
                        r_ctl    <= {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
                        r_k      <= 2'd0;
                        r_carry  <= 1'b0;
                        r_result <= '0;
                        r_nz_acc <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[w_base +: ALU_SLICE_W] <= w_slice_out;
                    r_carry  <= w_slice_cout;
                    r_nz_acc <= r_nz_acc | (|w_slice_out);
                    r_k      <= r_k + 2'd1;
                    if (r_k == c_K_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out       = r_result;
    assign bus.zr        = ~r_nz_acc;
    assign bus.ng        = r_result[ALU_W-1];
    assign bus.cout      = r_carry;

endmodule : alu16_serial
`default_nettype wire
